// File: rtl/ads1675_pkg.sv
// Shared definitions for the ADS1675 serial link emulator and its receiver.
package ads1675_pkg;

  localparam int ADS1675_DW    = 24;
  localparam int ADS1675_FRAME = 32;

  typedef logic signed [ADS1675_DW-1:0] ads1675_sample_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ads1675_sclk_gen.sv
// sclk divider: toggles sclk every DIV enabled aclk cycles and flags the
// aclk cycle on which each rising or falling sclk edge is registered.
module ads1675_sclk_gen
  import ads1675_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int HW = cnt_width(DIV);
  localparam logic [HW-1:0] HMAX = HW'(DIV - 1);

  logic [HW-1:0] hcnt;
  logic          toggle;

  assign toggle = en && (hcnt == HMAX);
  assign rise   = toggle && !sclk;
  assign fall   = toggle && sclk;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hcnt <= '0;
      sclk <= 1'b0;
    end else if (en) begin
      if (toggle) begin
        hcnt <= '0;
        sclk <= ~sclk;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ads1675_tx.sv
// ADS1675 output-side emulator: accepts samples over valid/ready and drives
// sclk, drdy and dout with the ADC's frame timing.
module ads1675_tx
  import ads1675_pkg::*;
#(
  parameter int DW    = ADS1675_DW,
  parameter int DIV   = 2,
  parameter int FRAME = ADS1675_FRAME
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          en,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          sclk,
  output logic          drdy,
  output logic          dout,
  output logic          underrun
);

  if (DIV < 1) begin : g_bad_div
    $error("ads1675_tx: DIV must be at least 1");
  end
  if (FRAME < DW + 1) begin : g_bad_frame
    $error("ads1675_tx: FRAME must be at least DW+1");
  end
  if (DW < 2) begin : g_bad_dw
    $error("ads1675_tx: DW must be at least 2");
  end

  localparam int BW = cnt_width(FRAME);
  localparam logic [BW-1:0] BLAST = BW'(FRAME - 1);
  localparam logic [BW-1:0] BDW   = BW'(DW);

  logic                 rise;
  logic                 fall_unused;
  logic [BW-1:0]        bcnt;
  logic [BW-1:0]        bnext;
  logic                 frame_start;
  logic                 accept;
  logic                 hold_full;
  logic signed [DW-1:0] hold;
  logic signed [DW-1:0] last;
  logic signed [DW-1:0] shift;
  logic signed [DW-1:0] load_word;

  ads1675_sclk_gen #(.DIV(DIV)) u_sclk_gen (
    .aclk   (aclk),
    .areset (areset),
    .en     (en),
    .sclk   (sclk),
    .rise   (rise),
    .fall   (fall_unused)
  );

  assign bnext       = (bcnt == BLAST) ? '0 : bcnt + 1'b1;
  assign frame_start = rise && (bcnt == BLAST);
  assign s_ready     = !hold_full;
  assign accept      = s_valid && !hold_full;
  // With nothing new in the holding register the ADC repeats its last word.
  assign load_word   = hold_full ? hold : last;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hold_full <= 1'b0;
      hold      <= '0;
      last      <= '0;
      shift     <= '0;
      bcnt      <= BLAST;
      drdy      <= 1'b0;
      dout      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (accept) begin
        hold      <= $signed(s_data);
        hold_full <= 1'b1;
      end
      if (rise) begin
        bcnt <= bnext;
        drdy <= frame_start;
        if (frame_start) begin
          shift <= load_word;
          dout  <= load_word[DW-1];
          if (hold_full) begin
            last      <= hold;
            hold_full <= 1'b0;
          end else begin
            underrun <= 1'b1;
          end
        end else if (bnext < BDW) begin
          // MSB went out at frame start; each later rise presents the next bit.
          dout  <= shift[DW-2];
          shift <= {shift[DW-2:0], 1'b0};
        end else begin
          dout <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ads1675_tx.sv
// Directed bench for ads1675_tx with a frame monitor and a behavioural receiver.
module tb_ads1675_tx;
  import ads1675_pkg::*;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        en = 1'b1;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        sclk;
  logic        drdy;
  logic        dout;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  ads1675_tx #(.DW(24), .DIV(2), .FRAME(32)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .en       (en),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .sclk     (sclk),
    .drdy     (drdy),
    .dout     (dout),
    .underrun (underrun)
  );

  always #5 aclk = ~aclk;

  // Frame monitor: dout at each of the 32 sclk rises from a drdy edge.
  logic        sclk_q = 1'b0;
  logic        drdy_q = 1'b0;
  logic [31:0] mon_bits = '0;
  int          mon_n = 0;
  int          mon_un = 0;
  int          mon_starts = 0;
  logic [31:0] frames[$];
  int          unq[$];

  always @(negedge aclk) begin
    sclk_q <= sclk;
    drdy_q <= drdy;
    if (areset) begin
      mon_n <= 0;
    end else if (sclk && !sclk_q && drdy && !drdy_q) begin
      mon_starts <= mon_starts + 1;
      mon_bits   <= {31'd0, dout};
      mon_n      <= 1;
      mon_un     <= underrun ? 1 : 0;
    end else if (mon_n != 0) begin
      if (underrun) mon_un <= mon_un + 1;
      if (sclk && !sclk_q) begin
        mon_bits <= {mon_bits[30:0], dout};
        if (mon_n == 31) begin
          frames.push_back({mon_bits[30:0], dout});
          unq.push_back(mon_un + (underrun ? 1 : 0));
          mon_n <= 0;
        end else begin
          mon_n <= mon_n + 1;
        end
      end
    end
  end

  // Receiver: samples dout on sclk falls, latches the word on drdy rise.
  logic            rs_q = 1'b0;
  logic            rd_q = 1'b0;
  ads1675_sample_t rx_sr = '0;
  int              rx_cnt = 24;
  int              rx_pulses = 0;
  ads1675_sample_t rxq[$];

  always @(negedge aclk) begin
    rs_q <= sclk;
    rd_q <= drdy;
    if (drdy && !rd_q) begin
      rxq.push_back(rx_sr);
      rx_cnt    <= 0;
      rx_pulses <= rx_pulses + 1;
    end else if (!sclk && rs_q && rx_cnt < 24) begin
      rx_sr  <= {rx_sr[22:0], dout};
      rx_cnt <= rx_cnt + 1;
    end
  end

  task automatic push(input logic [23:0] w, output int k);
    int n = 0;
    @(negedge aclk);
    s_data  = w;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 600) begin
      @(negedge aclk);
      n++;
    end
    @(posedge aclk);
    #1 s_valid = 1'b0;
    @(negedge aclk);
    #1 k = mon_starts;
  endtask

  task automatic get_frame(input int k, output logic [31:0] bits, output int un);
    int n = 0;
    while (frames.size() <= k && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    if (frames.size() <= k) begin
      bits = 'x;
      un   = -1;
    end else begin
      bits = frames[k];
      un   = unq[k];
    end
  endtask

  task automatic wait_start(input int k);
    int n = 0;
    while (mon_starts <= k && n < 600) begin
      @(negedge aclk);
      #1 n++;
    end
  endtask

  task automatic wait_rises(input int cnt);
    int r = 0, n = 0;
    logic ps;
    ps = sclk;
    while (r < cnt && n < 600) begin
      @(negedge aclk);
      #1 if (sclk && !ps) r++;
      ps = sclk;
      n++;
    end
  endtask

  task automatic test_reset;
    logic [3:0]  sp;
    logic [31:0] b;
    int hi = 1, un = 0, u;
    repeat (3) @(negedge aclk);
    checks++;
    if ({sclk, drdy, dout, underrun, s_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state: got %b, want 00001", {sclk, drdy, dout, underrun, s_ready});
    end
    areset = 1'b0;
    @(posedge aclk); #1;
    checks++;
    if (sclk !== 1'b0) begin
      errors++;
      $display("FAIL first_edge_early: sclk=%b, want 0", sclk);
    end
    @(posedge aclk); #1;
    checks++;
    if ({sclk, drdy, underrun, dout} !== 4'b1110) begin
      errors++;
      $display("FAIL first_frame_start: sclk/drdy/underrun/dout=%b, want 1110",
               {sclk, drdy, underrun, dout});
    end
    for (int e = 3; e <= 129; e++) begin
      @(posedge aclk); #1;
      if (e <= 6) sp[6-e] = sclk;
      if (drdy) hi++;
      if (underrun) un++;
    end
    checks++;
    if (sp !== 4'b1001) begin
      errors++;
      $display("FAIL sclk_period: pattern=%b, want 1001", sp);
    end
    checks++;
    if (hi !== 4) begin
      errors++;
      $display("FAIL drdy_width: high %0d aclk, want 4", hi);
    end
    checks++;
    if (un !== 0) begin
      errors++;
      $display("FAIL underrun_width: extra %0d cycles, want 0", un);
    end
    @(posedge aclk); #1;
    checks++;
    if ({drdy, underrun} !== 2'b11) begin
      errors++;
      $display("FAIL second_frame_start: drdy/underrun=%b, want 11", {drdy, underrun});
    end
    get_frame(0, b, u);
    checks++;
    if (b !== 32'h0) begin
      errors++;
      $display("FAIL empty_frame_bits: got %h, want 00000000", b);
    end
    checks++;
    if (u !== 1) begin
      errors++;
      $display("FAIL empty_frame_underrun: got %0d, want 1", u);
    end
  endtask

  task automatic test_pattern;
    logic [31:0] b;
    int k, u;
    push(24'hA5F00F, k);
    get_frame(k, b, u);
    checks++;
    if (b !== {24'hA5F00F, 8'h00}) begin
      errors++;
      $display("FAIL pattern_bits: got %h, want a5f00f00", b);
    end
    checks++;
    if (u !== 0) begin
      errors++;
      $display("FAIL pattern_underrun: got %0d, want 0", u);
    end
  endtask

  task automatic test_loopback;
    int k0, k1, k2, n = 0, p0, p1;
    push(24'h000001, k0);
    push(24'h800000, k1);
    push(24'hFFFFFF, k2);
    checks++;
    if (k1 !== k0 + 1 || k2 !== k1 + 1) begin
      errors++;
      $display("FAIL loop_frame_slots: got %0d %0d %0d, want consecutive", k0, k1, k2);
    end
    while (rxq.size() <= k2 + 1 && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (int'(rxq[k0+1]) !== 1) begin
      errors++;
      $display("FAIL loop_rx_pos1: got %0d, want 1", int'(rxq[k0+1]));
    end
    checks++;
    if (int'(rxq[k1+1]) !== -8388608) begin
      errors++;
      $display("FAIL loop_rx_min: got %0d, want -8388608", int'(rxq[k1+1]));
    end
    checks++;
    if (int'(rxq[k2+1]) !== -1) begin
      errors++;
      $display("FAIL loop_rx_neg1: got %0d, want -1", int'(rxq[k2+1]));
    end
    @(negedge aclk);
    #1 p0 = rx_pulses;
    repeat (384) @(negedge aclk);
    #1 p1 = rx_pulses;
    checks++;
    if (p1 - p0 !== 3) begin
      errors++;
      $display("FAIL loop_valid_rate: got %0d pulses in 3 frames, want 3", p1 - p0);
    end
  endtask

  task automatic test_repeat;
    logic [31:0] b;
    int k, u;
    push(24'h123456, k);
    get_frame(k, b, u);
    checks++;
    if (b !== {24'h123456, 8'h00} || u !== 0) begin
      errors++;
      $display("FAIL repeat_first: got %h un=%0d, want 12345600 un=0", b, u);
    end
    get_frame(k + 1, b, u);
    checks++;
    if (b !== {24'h123456, 8'h00}) begin
      errors++;
      $display("FAIL repeat_bits: got %h, want 12345600", b);
    end
    checks++;
    if (u !== 1) begin
      errors++;
      $display("FAIL repeat_underrun: got %0d cycles, want 1", u);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] b;
    int k, k2, u, viol = 0, n = 0;
    push(24'h111111, k);
    while (mon_starts == k && n < 400) begin
      if (s_ready !== 1'b0) viol++;
      @(negedge aclk);
      #1 n++;
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL b2b_ready_low: s_ready high %0d cycles before frame start, want 0", viol);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_reopen: s_ready=%b after frame start, want 1", s_ready);
    end
    push(24'h222222, k2);
    checks++;
    if (k2 !== k + 1) begin
      errors++;
      $display("FAIL b2b_slot: second word slot %0d, want %0d", k2, k + 1);
    end
    get_frame(k, b, u);
    checks++;
    if (b !== {24'h111111, 8'h00}) begin
      errors++;
      $display("FAIL b2b_first: got %h, want 11111100", b);
    end
    get_frame(k + 1, b, u);
    checks++;
    if (b !== {24'h222222, 8'h00} || u !== 0) begin
      errors++;
      $display("FAIL b2b_second: got %h un=%0d, want 22222200 un=0", b, u);
    end
  endtask

  task automatic test_stall;
    logic [31:0] b;
    logic [2:0]  snap;
    int k, u, viol = 0;
    push(24'hC3A55A, k);
    wait_start(k);
    wait_rises(7);
    checks++;
    if (dout !== 1'b1) begin
      errors++;
      $display("FAIL stall_bit7: dout=%b, want 1", dout);
    end
    snap = {sclk, drdy, dout};
    en = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      #1 if ({sclk, drdy, dout} !== snap) viol++;
    end
    en = 1'b1;
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL stall_frozen: outputs moved on %0d of 10 cycles, want 0", viol);
    end
    get_frame(k, b, u);
    checks++;
    if (b !== {24'hC3A55A, 8'h00}) begin
      errors++;
      $display("FAIL stall_resume: got %h, want c3a55a00", b);
    end
  endtask

  task automatic test_reset_mid;
    int k, k2;
    push(24'hFFFFFF, k);
    wait_start(k);
    push(24'h0F0F0F, k2);
    wait_rises(3);
    checks++;
    if ({sclk, dout, s_ready} !== 3'b110) begin
      errors++;
      $display("FAIL mid_precondition: sclk/dout/s_ready=%b, want 110", {sclk, dout, s_ready});
    end
    #2 areset = 1'b1;
    #1;
    checks++;
    if ({sclk, drdy, dout, underrun, s_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL mid_reset_async: got %b, want 00001", {sclk, drdy, dout, underrun, s_ready});
    end
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk); #1;
    checks++;
    if (sclk !== 1'b0) begin
      errors++;
      $display("FAIL mid_release_early: sclk=%b, want 0", sclk);
    end
    @(posedge aclk); #1;
    checks++;
    if ({sclk, drdy, underrun, dout} !== 4'b1110) begin
      errors++;
      $display("FAIL mid_release_start: sclk/drdy/underrun/dout=%b, want 1110",
               {sclk, drdy, underrun, dout});
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_loopback();
    test_repeat();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
